// File: rtl/drop_pkg.sv
// Shared definitions for the drop timer: state encoding, default width and the
// sensor-sum scale factor used to derive the time limit.
package drop_pkg;

  localparam int unsigned TwDefault = 16;
  localparam int unsigned SumScale  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StCount,
    StHold
  } state_e;

  // Four 8-bit sensors fit in 10 bits; scaling by 4 needs 12.
  function automatic logic [11:0] scaled_sum(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
    logic [9:0] sum;
    sum = 10'(a) + 10'(b) + 10'(c) + 10'(d);
    return 12'(sum) * 12'(SumScale);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/drop_timer.sv
// Measures elapsed ticks against a limit derived from four height sensors and
// latches an operator drop request until the next start.
module drop_timer
  import drop_pkg::*;
#(
  parameter int unsigned TW = TwDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    sensor1,
  input  logic [7:0]    sensor2,
  input  logic [7:0]    sensor3,
  input  logic [7:0]    sensor4,
  input  logic          start,
  input  logic          tick,
  input  logic          drop_req,
  output logic [TW-1:0] t_act,
  output logic [TW-1:0] t_lim,
  output logic          drop_en,
  output logic          busy
);

  state_e      state_q;
  logic [11:0] lim_full;
  logic        cnt_clr;
  logic        cnt_en;

  assign lim_full = scaled_sum(sensor1, sensor2, sensor3, sensor4);

  // Reset clears the counter through the same synchronous clear as SAMPLE.
  assign cnt_clr = !rst_n || (state_q == StSample);
  assign cnt_en  = (state_q == StCount) && tick;

  sat_counter #(
    .W(TW)
  ) u_t_act (
    .clk(clk),
    .clr(cnt_clr),
    .en (cnt_en),
    .q  (t_act)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_lim   <= '0;
      drop_en <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StSample;
            busy    <= 1'b1;
          end
        end
        StSample: begin
          t_lim   <= TW'(lim_full);
          state_q <= StCount;
          busy    <= 1'b1;
        end
        StCount: begin
          // Restart has priority over a drop request in the same cycle.
          if (start) begin
            state_q <= StSample;
            busy    <= 1'b1;
          end else if (drop_req) begin
            state_q <= StHold;
            drop_en <= 1'b1;
            busy    <= 1'b0;
          end
        end
        StHold: begin
          if (start) begin
            state_q <= StSample;
            drop_en <= 1'b0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          drop_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drop_timer.sv
// Bench for drop_timer: directed vector table, hand sequences and random stimulus
// checked against a reference model, on a 16-bit and a 4-bit instance.
module tb_drop_timer;

  localparam int TW  = 16;
  localparam int TWS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic tick = 1'b0;
  logic drop_req = 1'b0;
  logic [7:0] s1 = 8'd0, s2 = 8'd0, s3 = 8'd0, s4 = 8'd0;

  logic [TW-1:0]  t_act, t_lim;
  logic           drop_en, busy;
  logic [TWS-1:0] t_act_s, t_lim_s;
  logic           drop_en_s, busy_s;

  drop_timer #(.TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .sensor1(s1), .sensor2(s2), .sensor3(s3), .sensor4(s4),
    .start(start), .tick(tick), .drop_req(drop_req),
    .t_act(t_act), .t_lim(t_lim), .drop_en(drop_en), .busy(busy)
  );

  drop_timer #(.TW(TWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .sensor1(s1), .sensor2(s2), .sensor3(s3), .sensor4(s4),
    .start(start), .tick(tick), .drop_req(drop_req),
    .t_act(t_act_s), .t_lim(t_lim_s), .drop_en(drop_en_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0 idle, 1 sample, 2 count, 3 hold.
  int m_phase = 0;
  int m_act = 0;
  int m_act_s = 0;
  int m_lim = 0;

  typedef struct {
    logic       rst_n, start, tick, drop;
    logic [7:0] s1, s2, s3, s4;
    int         e_act, e_lim;
    logic       e_den, e_busy;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_phase = 0; m_act = 0; m_act_s = 0; m_lim = 0;
    end else begin
      case (m_phase)
        0: if (start) m_phase = 1;
        1: begin
          m_lim   = (int'(s1) + int'(s2) + int'(s3) + int'(s4)) * 4;
          m_act   = 0;
          m_act_s = 0;
          m_phase = 2;
        end
        2: begin
          if (tick) begin
            if (m_act < (1 << TW) - 1) m_act++;
            if (m_act_s < (1 << TWS) - 1) m_act_s++;
          end
          if (start) m_phase = 1;
          else if (drop_req) m_phase = 3;
        end
        default: if (start) m_phase = 1;
      endcase
    end
  endtask

  task automatic model_check();
    chk("t_act", 32'(t_act), 32'(m_act));
    chk("t_lim", 32'(t_lim), 32'(m_lim % (1 << TW)));
    chk("drop_en", 32'(drop_en), 32'(m_phase == 3));
    chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    chk("t_act_tw4", 32'(t_act_s), 32'(m_act_s));
    chk("t_lim_tw4", 32'(t_lim_s), 32'(m_lim % (1 << TWS)));
    chk("drop_en_tw4", 32'(drop_en_s), 32'(m_phase == 3));
    chk("busy_tw4", 32'(busy_s), 32'(m_phase == 1 || m_phase == 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    model_check();
  endtask

  task automatic drive(input logic r, input logic st, input logic tk, input logic dr);
    rst_n = r; start = st; tick = tk; drop_req = dr;
  endtask

  task automatic sensors(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d);
    s1 = a; s2 = b; s3 = c; s4 = d;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   0, 0,    1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1,   8'd1,   8'd1,   8'd2,   0, 0,    1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1,   8'd1,   8'd1,   8'd2,   0, 20,   1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd9,   8'd9,   8'd9,   8'd9,   1, 20,   1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd9,   8'd9,   8'd9,   8'd9,   2, 20,   1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd9,   8'd9,   8'd9,   8'd9,   3, 20,   1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd9,   8'd9,   8'd9,   8'd9,   3, 20,   1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd9,   8'd9,   8'd9,   8'd9,   3, 20,   1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd10,  8'd20,  8'd30,  8'd40,  3, 20,   1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd10,  8'd20,  8'd30,  8'd40,  0, 400,  1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd0,   8'd0,   8'd0,   8'd0,   1, 400,  1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 0, 4080, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 0, 0,    1'b0, 1'b0};

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst_n, tbl[i].start, tbl[i].tick, tbl[i].drop);
      sensors(tbl[i].s1, tbl[i].s2, tbl[i].s3, tbl[i].s4);
      step();
      chk($sformatf("tbl%0d_t_act", i), 32'(t_act), 32'(tbl[i].e_act));
      chk($sformatf("tbl%0d_t_lim", i), 32'(t_lim), 32'(tbl[i].e_lim));
      chk($sformatf("tbl%0d_drop_en", i), 32'(drop_en), 32'(tbl[i].e_den));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
    end

    // Tick and drop together at t_act=7 freeze at 8.
    sensors(8'd1, 8'd2, 8'd3, 8'd4);
    drive(1'b1, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0); step();
    end
    chk("seq_act7", 32'(t_act), 32'd7);
    drive(1'b1, 1'b0, 1'b1, 1'b1); step();
    chk("seq_hold_act8", 32'(t_act), 32'd8);
    chk("seq_hold_den", 32'(drop_en), 32'd1);
    chk("seq_hold_busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0); step();
    chk("seq_hold_frozen", 32'(t_act), 32'd8);

    // Restart from HOLD, count to 5, then reset mid-COUNT.
    drive(1'b1, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0); step();
    end
    chk("seq_act5", 32'(t_act), 32'd5);
    drive(1'b0, 1'b0, 1'b1, 1'b0); step();
    chk("seq_rst_act", 32'(t_act), 32'd0);
    chk("seq_rst_lim", 32'(t_lim), 32'd0);
    chk("seq_rst_den", 32'(drop_en), 32'd0);
    chk("seq_rst_busy", 32'(busy), 32'd0);
    sensors(8'd3, 8'd3, 8'd3, 8'd3);
    drive(1'b1, 1'b1, 1'b0, 1'b0); step();
    chk("seq_post_rst_busy", 32'(busy), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    chk("seq_post_rst_lim", 32'(t_lim), 32'd48);

    // Saturation on the 4-bit build.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0); step();
    end
    chk("seq_sat_tw4", 32'(t_act_s), 32'd15);
    chk("seq_tw16_20", 32'(t_act), 32'd20);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 9) == 0),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 7) == 0));
      sensors(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/drop_timer.md
DROP_TIMER -- requirements
Module: drop_timer

Interface
REQ-001 SHALL have parameter TW, default 16: width of t_act and t_lim.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port sensor1  input  8  height sensor 1, unsigned.
REQ-005 SHALL have port sensor2  input  8  height sensor 2, unsigned.
REQ-006 SHALL have port sensor3  input  8  height sensor 3, unsigned.
REQ-007 SHALL have port sensor4  input  8  height sensor 4, unsigned.
REQ-008 SHALL have port start  input  1  level-sampled request to begin or restart a measurement.
REQ-009 SHALL have port tick  input  1  one-cycle time-base pulse.
REQ-010 SHALL have port drop_req  input  1  operator drop request.
REQ-011 SHALL have port t_act  output  TW  elapsed ticks since measurement start; feeds display_and_drop.
REQ-012 SHALL have port t_lim  output  TW  computed time limit; feeds display_and_drop.
REQ-013 SHALL have port drop_en  output  1  drop requested; feeds display_and_drop.
REQ-014 SHALL have port busy  output  1  high in SAMPLE or COUNT.

Function
REQ-015 SHALL implement FSM with states IDLE, SAMPLE, COUNT, HOLD; all outputs registered.
REQ-016 In IDLE: start=1 -> SAMPLE next cycle; otherwise stay; t_act=0, drop_en=0.
REQ-017 In SAMPLE (exactly 1 cycle): sum = sensor1+sensor2+sensor3+sensor4 (10-bit, no overflow); t_lim <= sum*4, zero-extended to TW; t_act <= 0; -> COUNT.
REQ-018 t_lim SHALL hold its value from SAMPLE until the next SAMPLE or reset; sensor changes outside SAMPLE are ignored.
REQ-019 In COUNT: tick=1 -> t_act+1, saturating at all-ones (no wrap).
REQ-020 In COUNT: drop_req=1 -> HOLD next cycle; drop_en=1 from the cycle after drop_req is sampled (1-cycle latency).
REQ-021 tick and drop_req in the same COUNT cycle: the increment is applied, then t_act freezes at the incremented value.
REQ-022 In HOLD: t_act frozen, drop_en=1, busy=0; start=1 -> SAMPLE (drop_en cleared next cycle); drop_req ignored.
REQ-023 start=1 in COUNT restarts: -> SAMPLE; start has priority over drop_req.
REQ-024 start=1 in SAMPLE is ignored.
REQ-025 tick outside COUNT SHALL NOT change t_act.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, t_act=0, t_lim=0, drop_en=0, busy=0, from any state, including mid-COUNT or mid-HOLD.
REQ-027 On the first edge with rst_n=1, start SHALL be honored normally.

Structure
REQ-028 Shared package drop_pkg SHALL hold the state encoding, TW default and the sum scale factor (4).
REQ-029 One sub-module, sat_counter (TW-bit, enable, clear, saturate), SHALL implement t_act.
REQ-030 SHALL not instantiate display_and_drop; the top level connects t_act/t_lim/drop_en directly.

Verification
REQ-031 Sensors 1,1,1,2; start pulse; 3 ticks; drop_req -> t_lim=20, t_act=3, drop_en=1 the cycle after drop_req.
REQ-032 Sensors 255 x4; start -> t_lim=4080, no truncation.
REQ-033 TW=4 build; 20 ticks in COUNT -> t_act holds 15, no wrap.
REQ-034 tick and drop_req in the same cycle with t_act=7 -> HOLD with t_act=8.
REQ-035 rst_n=0 mid-COUNT with t_act=5 -> next cycle all outputs 0 and state IDLE; start then t_lim recomputed.
REQ-036 In HOLD, start with new sensors 10,20,30,40 -> drop_en=0, t_act=0, t_lim=400 after SAMPLE.
